// File: rtl/darkmm_pkg.sv
// Shared types and helpers for the darkmm memory-map router.
package darkmm_pkg;

    localparam int MAX_SLV = 8;
    localparam int MAX_AW  = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic [MAX_AW-1:0] base;
        logic [MAX_AW-1:0] size;
    } region_t;

    // Pulls window idx out of packed base/size vectors whose per-slave stride is aw bits.
    function automatic region_t get_region(
        input logic [MAX_SLV*MAX_AW-1:0] bases,
        input logic [MAX_SLV*MAX_AW-1:0] sizes,
        input int                        idx,
        input int                        aw
    );
        region_t r;
        r = '0;
        for (int b = 0; b < aw; b++) begin
            r.base[b] = bases[idx*aw + b];
            r.size[b] = sizes[idx*aw + b];
        end
        return r;
    endfunction

endpackage

// File: rtl/darkmm_decode.sv
// Combinational address decoder: window hit test, lowest-index priority, base-relative address.
module darkmm_decode
    import darkmm_pkg::*;
#(
    parameter int                 NSLV     = 3,
    parameter int                 AW       = 32,
    parameter int                 IW       = 2,
    parameter logic [NSLV*AW-1:0] SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0] SLV_SIZE = '1
) (
    input  logic [AW-1:0]   addr,
    output logic [NSLV-1:0] hit_vec,
    output logic [IW-1:0]   hit_idx,
    output logic [AW-1:0]   rel_addr,
    output logic            miss
);

    region_t           regions  [NSLV];
    logic [MAX_AW-1:0] base_arr [NSLV];
    logic [NSLV-1:0]   raw_hit;
    logic [MAX_AW-1:0] addr_x;

    assign addr_x = MAX_AW'(addr);

    // Wider-than-AW arithmetic means a window never wraps around past the top of the address space.
    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_win
            assign regions[gi]  = get_region((MAX_SLV*MAX_AW)'(SLV_BASE),
                                             (MAX_SLV*MAX_AW)'(SLV_SIZE), gi, AW);
            assign base_arr[gi] = regions[gi].base;
            assign raw_hit[gi]  = (addr_x >= regions[gi].base) &&
                                  ((addr_x - regions[gi].base) < regions[gi].size);
        end
    endgenerate

    always_comb begin
        hit_idx = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (raw_hit[i]) begin
                hit_idx = IW'(i);
            end
        end
    end

    assign hit_vec  = raw_hit & ~(raw_hit - NSLV'(1));
    assign miss     = ~|raw_hit;
    assign rel_addr = AW'(addr_x - base_arr[hit_idx]);

endmodule

// File: rtl/darkmm_router.sv
// Memory-map router: one outstanding core access forwarded to the decoded slave, with
// registered response, bus error on miss/malformed request, and an ack timeout.
module darkmm_router
    import darkmm_pkg::*;
#(
    parameter int                 NSLV     = 3,
    parameter int                 AW       = 32,
    parameter int                 DW       = 32,
    parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NSLV*AW-1:0] SLV_SIZE = {32'hC000_0000, 32'h2000_0000, 32'h2000_0000},
    parameter int                 TMO_CYC  = 255
) (
    input  logic              XCLK,
    input  logic              XRES,
    input  logic              CORE_EN,
    input  logic              CORE_RE,
    input  logic              CORE_WE,
    input  logic [AW-1:0]     CORE_ADDR,
    input  logic [DW-1:0]     CORE_WDATA,
    output logic [DW-1:0]     CORE_RDATA,
    output logic              CORE_RACK,
    output logic              CORE_WACK,
    output logic              CORE_ERR,
    output logic [NSLV-1:0]   SLV_EN,
    output logic              SLV_RE,
    output logic              SLV_WE,
    output logic [AW-1:0]     SLV_ADDR,
    output logic [DW-1:0]     SLV_WDATA,
    input  logic [NSLV*DW-1:0] SLV_RDATA,
    input  logic [NSLV-1:0]   SLV_RACK,
    input  logic [NSLV-1:0]   SLV_WACK
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int TW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    genvar gi;
    generate
        if (NSLV < 1 || NSLV > MAX_SLV) begin : g_bad_nslv
            $error("darkmm_router: NSLV must be in 1..8");
        end
        if (AW > MAX_AW) begin : g_bad_aw
            $error("darkmm_router: AW exceeds 64");
        end
        for (gi = 0; gi < NSLV; gi++) begin : g_chk_size
            if (SLV_SIZE[gi*AW +: AW] == '0) begin : g_bad_size
                $error("darkmm_router: zero-sized slave window");
            end
        end
    endgenerate

    logic [NSLV-1:0] dec_hit;
    logic [IW-1:0]   dec_idx;
    logic [AW-1:0]   dec_rel;
    logic            dec_miss;

    darkmm_decode #(
        .NSLV     (NSLV),
        .AW       (AW),
        .IW       (IW),
        .SLV_BASE (SLV_BASE),
        .SLV_SIZE (SLV_SIZE)
    ) u_decode (
        .addr     (CORE_ADDR),
        .hit_vec  (dec_hit),
        .hit_idx  (dec_idx),
        .rel_addr (dec_rel),
        .miss     (dec_miss)
    );

    state_t          state_reg, state_next;
    logic [NSLV-1:0] en_reg, en_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic            re_reg, re_next;
    logic            we_reg, we_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   wdata_reg, wdata_next;
    logic [DW-1:0]   rdata_reg, rdata_next;
    logic            rack_reg, rack_next;
    logic            wack_reg, wack_next;
    logic            err_reg, err_next;
    logic [TW-1:0]   timer_reg, timer_next;

    logic            sel_ack;
    logic            tmo_hit;
    logic [DW-1:0]   sel_rdata;

    // Only the selected slave's ack of the matching type completes the access.
    assign sel_ack   = re_reg ? |(SLV_RACK & en_reg) : |(SLV_WACK & en_reg);
    assign sel_rdata = SLV_RDATA[idx_reg*DW +: DW];
    assign tmo_hit   = (TMO_CYC != 0) && (32'(timer_reg) == 32'(TMO_CYC - 1));

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        en_next    = en_reg;
        idx_next   = idx_reg;
        re_next    = re_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        timer_next = timer_reg;
        rack_next  = 1'b0;
        wack_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (CORE_EN) begin
                    if ((CORE_RE ^ CORE_WE) && !dec_miss) begin
                        state_next = ACCESS;
                        en_next    = dec_hit;
                        idx_next   = dec_idx;
                        re_next    = CORE_RE;
                        we_next    = CORE_WE;
                        addr_next  = dec_rel;
                        wdata_next = CORE_WDATA;
                        timer_next = '0;
                    end else begin
                        // Malformed requests (RE==WE) always answer with a write ack.
                        state_next = RESP;
                        err_next   = 1'b1;
                        rack_next  = CORE_RE & ~CORE_WE;
                        wack_next  = ~(CORE_RE & ~CORE_WE);
                        rdata_next = '0;
                    end
                end
            end
            ACCESS: begin
                if (sel_ack) begin
                    state_next = RESP;
                    en_next    = '0;
                    re_next    = 1'b0;
                    we_next    = 1'b0;
                    rack_next  = re_reg;
                    wack_next  = we_reg;
                    rdata_next = re_reg ? sel_rdata : '0;
                end else if (tmo_hit) begin
                    state_next = RESP;
                    en_next    = '0;
                    re_next    = 1'b0;
                    we_next    = 1'b0;
                    rack_next  = re_reg;
                    wack_next  = we_reg;
                    err_next   = 1'b1;
                    rdata_next = '0;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            en_reg    <= '0;
            idx_reg   <= '0;
            re_reg    <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            rack_reg  <= 1'b0;
            wack_reg  <= 1'b0;
            err_reg   <= 1'b0;
            timer_reg <= '0;
        end else begin
            en_reg    <= en_next;
            idx_reg   <= idx_next;
            re_reg    <= re_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            rack_reg  <= rack_next;
            wack_reg  <= wack_next;
            err_reg   <= err_next;
            timer_reg <= timer_next;
        end
    end

    assign SLV_EN     = en_reg;
    assign SLV_RE     = re_reg;
    assign SLV_WE     = we_reg;
    assign SLV_ADDR   = addr_reg;
    assign SLV_WDATA  = wdata_reg;
    assign CORE_RDATA = rdata_reg;
    assign CORE_RACK  = rack_reg;
    assign CORE_WACK  = wack_reg;
    assign CORE_ERR   = err_reg;

endmodule

// File: tb/tb_darkmm_router.sv
// Randomised bench for darkmm_router: the bench plays all slaves and predicts every response
// from the window table and the timeout/error rules.
module tb_darkmm_router;

    localparam int NSLV = 5;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int TMO  = 8;
    localparam logic [NSLV*AW-1:0] BASES =
        {32'hF000_0000, 32'h3800_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_0000};
    localparam logic [NSLV*AW-1:0] SIZES =
        {32'h2000_0000, 32'h1000_0000, 32'h4000_0000, 32'h2000_0000, 32'h0000_1000};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              core_en, core_re, core_we;
    logic [AW-1:0]     core_addr;
    logic [DW-1:0]     core_wdata, core_rdata;
    logic              core_rack, core_wack, core_err;
    logic [NSLV-1:0]   slv_en;
    logic              slv_re, slv_we;
    logic [AW-1:0]     slv_addr;
    logic [DW-1:0]     slv_wdata;
    logic [NSLV*DW-1:0] slv_rdata;
    logic [NSLV-1:0]   slv_rack, slv_wack;

    int n_vec = 0;
    int n_err = 0;

    longint unsigned win_base [NSLV] = '{64'h0, 64'h2000_0000, 64'h4000_0000, 64'h3800_0000, 64'hF000_0000};
    longint unsigned win_size [NSLV] = '{64'h1000, 64'h2000_0000, 64'h4000_0000, 64'h1000_0000, 64'h2000_0000};

    darkmm_router #(
        .NSLV     (NSLV),
        .AW       (AW),
        .DW       (DW),
        .SLV_BASE (BASES),
        .SLV_SIZE (SIZES),
        .TMO_CYC  (TMO)
    ) dut (
        .XCLK       (clk),
        .XRES       (rst_n),
        .CORE_EN    (core_en),
        .CORE_RE    (core_re),
        .CORE_WE    (core_we),
        .CORE_ADDR  (core_addr),
        .CORE_WDATA (core_wdata),
        .CORE_RDATA (core_rdata),
        .CORE_RACK  (core_rack),
        .CORE_WACK  (core_wack),
        .CORE_ERR   (core_err),
        .SLV_EN     (slv_en),
        .SLV_RE     (slv_re),
        .SLV_WE     (slv_we),
        .SLV_ADDR   (slv_addr),
        .SLV_WDATA  (slv_wdata),
        .SLV_RDATA  (slv_rdata),
        .SLV_RACK   (slv_rack),
        .SLV_WACK   (slv_wack)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lowest-numbered window containing the address, in plain 64-bit arithmetic; -1 on miss.
    function automatic int model_slave(input logic [31:0] addr);
        longint unsigned a;
        a = 64'(addr);
        for (int i = 0; i < NSLV; i++) begin
            if (a >= win_base[i] && a < win_base[i] + win_size[i]) return i;
        end
        return -1;
    endfunction

    task automatic do_txn(input logic [31:0] addr, input logic re, input logic we,
                          input int delay, input bit spur, input bit drop_en);
        int              sel, span;
        bit              bad, tmo, exp_rack;
        logic [DW-1:0]   wd, rd;
        logic [NSLV-1:0] onehot;
        logic [2:0]      seen;
        wd = $urandom;
        for (int i = 0; i < NSLV; i++) slv_rdata[i*DW +: DW] = $urandom;
        sel      = model_slave(addr);
        bad      = (re == we) || (sel < 0);
        tmo      = !bad && (delay >= TMO);
        exp_rack = re && !we;
        rd       = '0;
        onehot   = '0;
        if (!bad) begin
            onehot[sel] = 1'b1;
            if (re && !tmo) rd = slv_rdata[sel*DW +: DW];
        end
        core_en = 1'b1; core_re = re; core_we = we; core_addr = addr; core_wdata = wd;
        step();
        if (!bad) begin
            check_val("slv_en", slv_en, onehot);
            check_val("slv_addr", slv_addr, 32'(64'(addr) - win_base[sel]));
            check_val("slv_re", slv_re, re);
            check_val("slv_we", slv_we, we);
            if (we) check_val("slv_wdata", slv_wdata, wd);
            span = tmo ? TMO : delay;
            for (int c = 0; c < span; c++) begin
                if (drop_en && c == 0) core_en = 1'b0;
                if (spur) begin
                    slv_rack = NSLV'($urandom) & ~onehot;
                    slv_wack = NSLV'($urandom) & ~onehot;
                    if (re) slv_wack[sel] = 1'b1;
                    else    slv_rack[sel] = 1'b1;
                end
                step();
                slv_rack = '0;
                slv_wack = '0;
                if (!tmo || c < span - 1) check_val("en_held", slv_en, onehot);
            end
            if (!tmo) begin
                if (re) slv_rack[sel] = 1'b1;
                else    slv_wack[sel] = 1'b1;
                step();
                slv_rack = '0;
                slv_wack = '0;
            end
        end
        core_en = 1'b0;
        seen = {core_rack, core_wack, core_err};
        check_val("core_rack", core_rack, exp_rack);
        check_val("core_wack", core_wack, !exp_rack);
        check_val("core_err", core_err, bad || tmo);
        if (exp_rack) check_val("core_rdata", core_rdata, rd);
        check_val("resp_slv_en", slv_en, '0);
        step();
        check_val("pulse_end", {core_rack, core_wack, core_err, slv_en}, '0);
        $display("txn addr=%h re=%0b we=%0b slave=%0d delay=%0d -> rack=%0b wack=%0b err=%0b",
                 addr, re, we, sel, delay, seen[2], seen[1], seen[0]);
    endtask

    initial begin
        logic [31:0]     a;
        int              k, m, dly;
        logic            r, w;
        longint unsigned edge_addr;

        core_en = 1'b0; core_re = 1'b0; core_we = 1'b0;
        core_addr = '0; core_wdata = '0;
        slv_rdata = '0; slv_rack = '0; slv_wack = '0;
        step();
        step();
        check_val("reset_outs", {core_rdata, core_rack, core_wack, core_err, slv_en,
                                 slv_re, slv_we}, '0);
        check_val("reset_addr", {slv_addr, slv_wdata}, '0);
        rst_n = 1'b1;
        step();

        // Directed cases
        do_txn(32'h2000_0010, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        do_txn(32'h4000_0004, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        do_txn(32'h8000_0000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        do_txn(32'h2000_0000, 1'b1, 1'b0, 20, 1'b0, 1'b0);
        do_txn(32'h2000_0000, 1'b0, 1'b1, 20, 1'b0, 1'b0);
        do_txn(32'h2000_0040, 1'b1, 1'b0, TMO - 1, 1'b0, 1'b0);
        do_txn(32'h2000_0040, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        do_txn(32'h2000_0040, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        do_txn(32'h4000_0100, 1'b1, 1'b0, 3, 1'b1, 1'b0);
        do_txn(32'h3800_0000, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        do_txn(32'h4000_0000, 1'b0, 1'b1, 1, 1'b0, 1'b0);
        do_txn(32'h4800_0000, 1'b1, 1'b0, 1, 1'b0, 1'b0);
        do_txn(32'hFFFF_FFFC, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        do_txn(32'h0000_1000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        do_txn(32'h0000_0004, 1'b0, 1'b1, 4, 1'b0, 1'b1);

        // Window edges: last byte inside, first byte past the end
        for (int i = 0; i < NSLV; i++) begin
            edge_addr = win_base[i] + win_size[i] - 1;
            do_txn(32'(edge_addr), 1'b1, 1'b0, 0, 1'b0, 1'b0);
            edge_addr = win_base[i] + win_size[i];
            if (edge_addr < 64'h1_0000_0000) do_txn(32'(edge_addr), 1'b0, 1'b1, 0, 1'b0, 1'b0);
        end

        // Reset during ACCESS: strobes drop at once, next access is clean
        core_en = 1'b1; core_re = 1'b1; core_we = 1'b0; core_addr = 32'h2000_0010;
        step();
        check_val("pre_rst_en", slv_en, 5'b00010);
        rst_n = 1'b0;
        #1;
        check_val("async_rst", {slv_en, slv_re, slv_we, slv_addr, core_rack, core_err}, '0);
        core_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_val("post_rst_idle", {slv_en, core_rack, core_wack, core_err}, '0);
        do_txn(32'h2000_0010, 1'b1, 1'b0, 2, 1'b0, 1'b0);

        // Randomised traffic
        for (int t = 0; t < 200; t++) begin
            k = $urandom_range(0, NSLV);
            if (k == NSLV) a = $urandom;
            else           a = 32'(win_base[k] + (64'($urandom) % win_size[k]));
            m = $urandom_range(0, 9);
            r = (m == 1) || (m >= 2 && m <= 5);
            w = (m == 1) || (m >= 6);
            dly = $urandom_range(0, 11);
            do_txn(a, r, w, dly, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
